// File: rtl/rand_slot_picker_if.sv
// Handshake bundle between the game controller/LFSR side and rand_slot_picker.
// The master drives the random word and requests; the slave returns picks.
interface rand_slot_picker_if;
    logic [29:0] rand_in;
    logic        req;
    logic        clr_hist;
    logic        busy;
    logic        pick_valid;
    logic [3:0]  pick;

    modport master (
        output rand_in,
        output req,
        output clr_hist,
        input  busy,
        input  pick_valid,
        input  pick
    );

    modport slave (
        input  rand_in,
        input  req,
        input  clr_hist,
        output busy,
        output pick_valid,
        output pick
    );
endinterface

// File: rtl/rand_slot_picker.sv
// Turns a 30-bit LFSR word into an unbiased slot index by rejection sampling of
// its nibbles, never reusing a word and never repeating the previous pick.
module rand_slot_picker #(
    parameter int NUM_SLOTS = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    rand_slot_picker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRESH = 2'd1,
        SCAN       = 2'd2
    } state_t;

    localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLOTS);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [27:0] work_r;
    logic [29:0] prev_word_r;
    logic [2:0]  idx_r;
    logic [3:0]  last_pick_r;
    logic        last_valid_r;
    logic [3:0]  pick_r;
    logic        pick_valid_r;
    logic        busy_r;

    logic [3:0]  nib_s;
    logic        fresh_s;
    logic        load_s;
    logic        accept_s;
    logic        advance_s;

    function automatic logic [3:0] nib_sel(input logic [27:0] w, input logic [2:0] i);
        logic [3:0] n;
        case (i)
            3'd0:    n = w[3:0];
            3'd1:    n = w[7:4];
            3'd2:    n = w[11:8];
            3'd3:    n = w[15:12];
            3'd4:    n = w[19:16];
            3'd5:    n = w[23:20];
            3'd6:    n = w[27:24];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req) state_nxt_s = WAIT_FRESH;
                else         state_nxt_s = IDLE;
            end
            WAIT_FRESH: begin
                if (fresh_s) state_nxt_s = SCAN;
                else         state_nxt_s = WAIT_FRESH;
            end
            SCAN: begin
                if (accept_s)             state_nxt_s = IDLE;
                else if (idx_r == 3'd6)   state_nxt_s = WAIT_FRESH;
                else                      state_nxt_s = SCAN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-state datapath controls; a nibble is usable only if in range and not a repeat
    always_comb begin
        nib_s     = nib_sel(work_r, idx_r);
        fresh_s   = (bus.rand_in != prev_word_r);
        load_s    = 1'b0;
        accept_s  = 1'b0;
        advance_s = 1'b0;
        case (state_r)
            WAIT_FRESH: begin
                load_s = fresh_s;
            end
            SCAN: begin
                if (({1'b0, nib_s} < SLOT_LIMIT) && !(last_valid_r && (nib_s == last_pick_r))) begin
                    accept_s = 1'b1;
                end else begin
                    advance_s = (idx_r != 3'd6);
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r       <= 28'd0;
            prev_word_r  <= 30'd0;
            idx_r        <= 3'd0;
            last_pick_r  <= 4'd0;
            last_valid_r <= 1'b0;
            pick_r       <= 4'd0;
            pick_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (load_s) begin
                work_r      <= bus.rand_in[27:0];
                prev_word_r <= bus.rand_in;
                idx_r       <= 3'd0;
            end else if (advance_s) begin
                idx_r <= idx_r + 3'd1;
            end
            if (accept_s) begin
                pick_r      <= nib_s;
                last_pick_r <= nib_s;
            end
            // An accept on the same edge as clr_hist keeps the new pick as history
            if (accept_s)          last_valid_r <= 1'b1;
            else if (bus.clr_hist) last_valid_r <= 1'b0;
            pick_valid_r <= accept_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign bus.busy       = busy_r;
    assign bus.pick_valid = pick_valid_r;
    assign bus.pick       = pick_r;

endmodule

// File: tb/tb_rand_slot_picker.sv
// Scoreboard bench for rand_slot_picker: a 9-slot and a 16-slot instance.
module tb_rand_slot_picker;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   pv9;
    int   pv16;
    logic [3:0] q9[$];
    logic [3:0] q16[$];

    rand_slot_picker_if if9 ();
    rand_slot_picker_if if16 ();

    rand_slot_picker #(.NUM_SLOTS(9)) dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if9.slave)
    );

    rand_slot_picker #(.NUM_SLOTS(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pick_valid pops the oldest expected pick
    always @(posedge clk) begin
        #1;
        if (if9.pick_valid === 1'b1) begin
            pv9++;
            if (q9.size() == 0) check_val("sb9_unexpected_pick", 32'd1, 32'd0);
            else                check_val("sb9_pick", {28'd0, if9.pick}, {28'd0, q9.pop_front()});
        end
        if (if16.pick_valid === 1'b1) begin
            pv16++;
            if (q16.size() == 0) check_val("sb16_unexpected_pick", 32'd1, 32'd0);
            else                 check_val("sb16_pick", {28'd0, if16.pick}, {28'd0, q16.pop_front()});
        end
    end

    function automatic logic get_pv(input bit sel);
        return sel ? if16.pick_valid : if9.pick_valid;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? if16.busy : if9.busy;
    endfunction

    // Waits (bounded) for pick_valid; cnt = posedges since the driving negedge
    task automatic wait_pick(input bit sel, input int start, input int budget, output int cnt);
        cnt = start;
        while (get_pv(sel) !== 1'b1 && cnt < budget) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (get_pv(sel) !== 1'b1) check_val("timeout_pick_valid", 32'd0, 32'd1);
    endtask

    task automatic run_pick(input bit sel, input logic [29:0] word, input logic [3:0] exp_pick,
                            input int exp_lat, input string tag);
        int cnt;
        @(negedge clk);
        if (sel) begin if16.rand_in = word; if16.req = 1'b1; q16.push_back(exp_pick); end
        else     begin if9.rand_in  = word; if9.req  = 1'b1; q9.push_back(exp_pick);  end
        @(posedge clk); #1;
        if9.req = 1'b0; if16.req = 1'b0;
        check_val({tag, "_busy_rise"}, {31'd0, get_busy(sel)}, 32'd1);
        wait_pick(sel, 1, 40, cnt);
        check_val({tag, "_latency"}, cnt, exp_lat);
        check_val({tag, "_busy_fall"}, {31'd0, get_busy(sel)}, 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_pulse_width"}, {31'd0, get_pv(sel)}, 32'd0);
    endtask

    initial begin
        int cnt;
        int pv_snap;
        n_checks = 0; n_errors = 0; pv9 = 0; pv16 = 0;
        if9.rand_in = 30'd0;  if9.req = 1'b0;  if9.clr_hist = 1'b0;
        if16.rand_in = 30'd0; if16.req = 1'b0; if16.clr_hist = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, if9.busy}, 32'd0);
        check_val("rst_pv", {31'd0, if9.pick_valid}, 32'd0);
        check_val("rst_pick", {28'd0, if9.pick}, 32'd0);
        check_val("rst16_busy", {31'd0, if16.busy}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Fresh word, accept on nibble 0
        run_pick(1'b0, 30'h0000_0005, 4'd5, 3, "fresh");

        // Stale word keeps the block waiting
        pv_snap = pv9;
        @(negedge clk); if9.req = 1'b1;
        @(negedge clk); if9.req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_val("stale_busy", {31'd0, if9.busy}, 32'd1);
        check_val("stale_no_pick", pv9, pv_snap);
        // New word: 5,5 rejected as repeats, 0 accepted on nibble 2
        @(negedge clk); if9.rand_in = 30'h0000_0055; q9.push_back(4'd0);
        @(posedge clk); #1;
        wait_pick(1'b0, 1, 40, cnt);
        check_val("repeat_latency", cnt, 4);

        // Full rejection, then a later fresh word
        pv_snap = pv9;
        @(negedge clk); if9.rand_in = 30'h0FFF_FFFF; if9.req = 1'b1;
        @(negedge clk); if9.req = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_val("reject_busy", {31'd0, if9.busy}, 32'd1);
        check_val("reject_no_pick", pv9, pv_snap);
        @(negedge clk); if9.rand_in = 30'h0000_0003; q9.push_back(4'd3);
        @(posedge clk); #1;
        wait_pick(1'b0, 1, 40, cnt);
        check_val("after_reject_latency", cnt, 2);

        // History clear lets 3 repeat; without it the 3 is skipped
        @(negedge clk); if9.clr_hist = 1'b1;
        @(negedge clk); if9.clr_hist = 1'b0;
        run_pick(1'b0, 30'h0000_0013, 4'd3, 3, "clr_hist");
        run_pick(1'b0, 30'h1000_0013, 4'd1, 4, "no_clr");

        // Extra req pulses during SCAN are ignored
        pv_snap = pv9;
        @(negedge clk); if9.rand_in = 30'h02FF_FFFF; if9.req = 1'b1; q9.push_back(4'd2);
        @(posedge clk); #1;
        cnt = 1;
        repeat (5) begin
            @(negedge clk); if9.req = ~if9.req;
            @(posedge clk); #1; cnt++;
        end
        if9.req = 1'b0;
        wait_pick(1'b0, cnt, 40, cnt);
        check_val("ignored_req_latency", cnt, 9);
        repeat (10) @(posedge clk);
        #1;
        check_val("ignored_req_one_pick", pv9, pv_snap + 1);
        check_val("ignored_req_idle", {31'd0, if9.busy}, 32'd0);

        // Asynchronous reset mid-scan drops the request
        pv_snap = pv9;
        @(negedge clk); if9.rand_in = 30'h03FF_FFFF; if9.req = 1'b1;
        @(negedge clk); if9.req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midreset_busy", {31'd0, if9.busy}, 32'd0);
        check_val("midreset_pv", {31'd0, if9.pick_valid}, 32'd0);
        check_val("midreset_pick", {28'd0, if9.pick}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_val("midreset_no_pick", pv9, pv_snap);
        check_val("midreset_idle", {31'd0, if9.busy}, 32'd0);

        // 16 slots: set history to 15, then 15,15 rejected as repeats
        run_pick(1'b1, 30'h0000_000F, 4'd15, 3, "s16_first");
        run_pick(1'b1, 30'h0000_00FF, 4'd0, 5, "s16_repeat");

        repeat (3) @(posedge clk);
        #1;
        check_val("sb9_drained", q9.size(), 32'd0);
        check_val("sb16_drained", q16.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
